// File: rtl/icache_pkg.sv
// Shared instruction-cache parameters, status-word layout, FSM encodings and NRU helper.
// Imported by the refill controller, the victim selector and the lookup stages.
package icache_pkg;

    localparam int unsigned SET_BITS_WIDTH  = 4;
    localparam int unsigned TAG_WIDTH       = 8;
    localparam int unsigned NUM_WAYS        = 4;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned WORDS_PER_LINE  = 4;

    localparam int unsigned WAY_IDX_WIDTH   = $clog2(NUM_WAYS);
    localparam int unsigned WORD_IDX_WIDTH  = $clog2(WORDS_PER_LINE);
    localparam int unsigned TA_WIDTH        = TAG_WIDTH * NUM_WAYS;
    localparam int unsigned SA_WIDTH        = 2 * NUM_WAYS;
    localparam int unsigned LINE_ADDR_WIDTH = TAG_WIDTH + SET_BITS_WIDTH;

    // Bit offsets inside each way's 2-bit status field
    localparam int unsigned SA_VALID_BIT  = 1;
    localparam int unsigned SA_RECENT_BIT = 0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFill,
        StUpdate,
        StDone
    } refill_state_e;

    // Mark a way valid+recent; once every way is recent, only the touched way keeps its bit.
    function automatic logic [SA_WIDTH-1:0] nru_touch(input logic [SA_WIDTH-1:0]      sa,
                                                      input logic [WAY_IDX_WIDTH-1:0] way);
        logic [SA_WIDTH-1:0] ns;
        logic                all_recent;
        ns = sa;
        ns[2*int'(way) + SA_VALID_BIT]  = 1'b1;
        ns[2*int'(way) + SA_RECENT_BIT] = 1'b1;
        all_recent = 1'b1;
        for (int w = 0; w < NUM_WAYS; w++) begin
            all_recent = all_recent & ns[2*w + SA_RECENT_BIT];
        end
        if (all_recent) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w != int'(way)) begin
                    ns[2*w + SA_RECENT_BIT] = 1'b0;
                end
            end
        end
        return ns;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// NRU victim selection: first invalid way, else first non-recent way, else way 0.
// Also returns the status word after touching the chosen way.
module icache_victim_sel
    import icache_pkg::*;
(
    input  logic [SA_WIDTH-1:0]      sa_data,
    output logic [WAY_IDX_WIDTH-1:0] victim,
    output logic [SA_WIDTH-1:0]      new_sa_data
);

    logic found;

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !sa_data[2*w + SA_VALID_BIT]) begin
                victim = WAY_IDX_WIDTH'(w);
                found  = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !sa_data[2*w + SA_RECENT_BIT]) begin
                victim = WAY_IDX_WIDTH'(w);
                found  = 1'b1;
            end
        end
        new_sa_data = nru_touch(sa_data, victim);
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: picks an NRU victim, fetches the line over valid/ready and
// writes the data, tag and status arrays.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        i_halt,

    input  logic                        i_miss_valid,
    output logic                        o_miss_ready,
    input  logic [SET_BITS_WIDTH-1:0]   i_miss_set_addr,
    input  logic [TAG_WIDTH-1:0]        i_miss_tag,
    input  logic [SA_WIDTH-1:0]         i_miss_sa_data,

    output logic                        o_mem_req_valid,
    input  logic                        i_mem_req_ready,
    output logic [LINE_ADDR_WIDTH-1:0]  o_mem_req_addr,

    input  logic                        i_mem_rsp_valid,
    output logic                        o_mem_rsp_ready,
    input  logic [WORD_WIDTH-1:0]       i_mem_rsp_data,

    output logic                        o_w_da_valid,
    output logic [SET_BITS_WIDTH-1:0]   o_w_da_set_addr,
    output logic [WAY_IDX_WIDTH-1:0]    o_w_da_way,
    output logic [WORD_IDX_WIDTH-1:0]   o_w_da_word,
    output logic [WORD_WIDTH-1:0]       o_w_da_data,

    output logic                        o_w_ta_valid,
    output logic [SET_BITS_WIDTH-1:0]   o_w_ta_set_addr,
    output logic [TA_WIDTH-1:0]         o_w_ta_data,
    output logic [NUM_WAYS-1:0]         o_w_ta_mask,

    output logic                        o_w_sa_valid,
    output logic [SET_BITS_WIDTH-1:0]   o_w_sa_set_addr,
    output logic [SA_WIDTH-1:0]         o_w_sa_data,
    output logic [NUM_WAYS-1:0]         o_w_sa_mask,

    output logic                        o_miss_state,
    output logic                        o_refill_done,
    output logic [WAY_IDX_WIDTH-1:0]    o_refill_way
);

    localparam logic [WORD_IDX_WIDTH-1:0] LastBeat = WORD_IDX_WIDTH'(WORDS_PER_LINE - 1);

    refill_state_e               state_q, state_d;
    logic [SET_BITS_WIDTH-1:0]   set_q, set_d;
    logic [TAG_WIDTH-1:0]        tag_q, tag_d;
    logic [WAY_IDX_WIDTH-1:0]    victim_q, victim_d;
    logic [SA_WIDTH-1:0]         new_sa_q, new_sa_d;
    logic [WORD_IDX_WIDTH-1:0]   beat_q, beat_d;

    logic [WAY_IDX_WIDTH-1:0]    sel_victim;
    logic [SA_WIDTH-1:0]         sel_new_sa;

    icache_victim_sel u_victim_sel (
        .sa_data     (i_miss_sa_data),
        .victim      (sel_victim),
        .new_sa_data (sel_new_sa)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            set_q    <= '0;
            tag_q    <= '0;
            victim_q <= '0;
            new_sa_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            set_q    <= set_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            new_sa_q <= new_sa_d;
            beat_q   <= beat_d;
        end
    end

    assign o_miss_state    = (state_q != StIdle);
    assign o_mem_req_addr  = {tag_q, set_q};
    assign o_w_da_set_addr = set_q;
    assign o_w_ta_set_addr = set_q;
    assign o_w_sa_set_addr = set_q;
    assign o_w_ta_data     = {NUM_WAYS{tag_q}};
    assign o_w_sa_data     = new_sa_q;

    always_comb begin
        state_d         = state_q;
        set_d           = set_q;
        tag_d           = tag_q;
        victim_d        = victim_q;
        new_sa_d        = new_sa_q;
        beat_d          = beat_q;
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        o_w_da_valid    = 1'b0;
        o_w_da_way      = '0;
        o_w_da_word     = '0;
        o_w_da_data     = '0;
        o_w_ta_valid    = 1'b0;
        o_w_ta_mask     = '0;
        o_w_sa_valid    = 1'b0;
        o_w_sa_mask     = '0;
        o_refill_done   = 1'b0;
        o_refill_way    = '0;

        unique case (state_q)
            StIdle: begin
                o_miss_ready = !i_halt;
                if (i_miss_valid && !i_halt) begin
                    set_d    = i_miss_set_addr;
                    tag_d    = i_miss_tag;
                    victim_d = sel_victim;
                    new_sa_d = sel_new_sa;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // Valid stays up through halt, so an accepted request must not be re-issued.
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                o_mem_rsp_ready = !i_halt;
                if (!i_halt && i_mem_rsp_valid) begin
                    o_w_da_valid = 1'b1;
                    o_w_da_way   = victim_q;
                    o_w_da_word  = beat_q;
                    o_w_da_data  = i_mem_rsp_data;
                    beat_d       = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                if (!i_halt) begin
                    o_w_ta_valid = 1'b1;
                    o_w_ta_mask  = NUM_WAYS'(1) << victim_q;
                    o_w_sa_valid = 1'b1;
                    o_w_sa_mask  = '1;
                    state_d      = StDone;
                end
            end
            StDone: begin
                if (!i_halt) begin
                    o_refill_done = 1'b1;
                    o_refill_way  = victim_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomised and directed bench for icache_refill_ctrl against a transaction-level model
// that tracks refill progress as request/beat/update/done milestones.
module tb_icache_refill_ctrl;

    logic        clk;
    logic        arst_n;
    logic        i_halt;
    logic        i_miss_valid;
    logic        o_miss_ready;
    logic [3:0]  i_miss_set_addr;
    logic [7:0]  i_miss_tag;
    logic [7:0]  i_miss_sa_data;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [11:0] o_mem_req_addr;
    logic        i_mem_rsp_valid;
    logic        o_mem_rsp_ready;
    logic [31:0] i_mem_rsp_data;
    logic        o_w_da_valid;
    logic [3:0]  o_w_da_set_addr;
    logic [1:0]  o_w_da_way;
    logic [1:0]  o_w_da_word;
    logic [31:0] o_w_da_data;
    logic        o_w_ta_valid;
    logic [3:0]  o_w_ta_set_addr;
    logic [31:0] o_w_ta_data;
    logic [3:0]  o_w_ta_mask;
    logic        o_w_sa_valid;
    logic [3:0]  o_w_sa_set_addr;
    logic [7:0]  o_w_sa_data;
    logic [3:0]  o_w_sa_mask;
    logic        o_miss_state;
    logic        o_refill_done;
    logic [1:0]  o_refill_way;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .i_halt          (i_halt),
        .i_miss_valid    (i_miss_valid),
        .o_miss_ready    (o_miss_ready),
        .i_miss_set_addr (i_miss_set_addr),
        .i_miss_tag      (i_miss_tag),
        .i_miss_sa_data  (i_miss_sa_data),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .o_mem_rsp_ready (o_mem_rsp_ready),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_w_da_valid    (o_w_da_valid),
        .o_w_da_set_addr (o_w_da_set_addr),
        .o_w_da_way      (o_w_da_way),
        .o_w_da_word     (o_w_da_word),
        .o_w_da_data     (o_w_da_data),
        .o_w_ta_valid    (o_w_ta_valid),
        .o_w_ta_set_addr (o_w_ta_set_addr),
        .o_w_ta_data     (o_w_ta_data),
        .o_w_ta_mask     (o_w_ta_mask),
        .o_w_sa_valid    (o_w_sa_valid),
        .o_w_sa_set_addr (o_w_sa_set_addr),
        .o_w_sa_data     (o_w_sa_data),
        .o_w_sa_mask     (o_w_sa_mask),
        .o_miss_state    (o_miss_state),
        .o_refill_done   (o_refill_done),
        .o_refill_way    (o_refill_way)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // NRU rules written directly from the status-word description
    function automatic void nru_model(input logic [7:0] sa, output int vic, output logic [7:0] ns);
        vic = -1;
        for (int w = 0; w < 4; w++) if (vic < 0 && !sa[2*w+1]) vic = w;
        for (int w = 0; w < 4; w++) if (vic < 0 && !sa[2*w]) vic = w;
        if (vic < 0) vic = 0;
        ns = sa;
        ns[2*vic +: 2] = 2'b11;
        if (ns[0] && ns[2] && ns[4] && ns[6])
            for (int w = 0; w < 4; w++) if (w != vic) ns[2*w] = 1'b0;
    endfunction

    // Model: a refill is busy until done; milestones are request accepted, beats, update, done.
    bit         m_busy = 0, m_req = 0, m_upd = 0;
    int         m_beats = 0, m_vic = 0;
    logic [3:0] m_set = '0;
    logic [7:0] m_tag = '0, m_nsa = '0;
    bit         ph_req, ph_fill, ph_upd, ph_done, e_mr, e_da, e_wr, e_dn;

    int          st_da, st_ta, st_done, st_req_cycles, st_miss_cyc, st_done_cyc;
    int          st_beat3_cyc, st_ta_cyc;
    logic [11:0] st_req_addr;
    logic [31:0] st_ta_data, st_da_first, st_da_last;
    logic [3:0]  st_ta_mask;
    logic [7:0]  st_sa_data, st_words;
    logic [1:0]  st_done_way;

    always @(negedge clk) begin
        cyc++;
        if (!arst_n) begin
            check("rst_miss_state", o_miss_state, 0);
            check("rst_miss_ready", o_miss_ready, !i_halt);
            check("rst_req_valid", o_mem_req_valid, 0);
            check("rst_req_addr", o_mem_req_addr, 0);
            check("rst_rsp_ready", o_mem_rsp_ready, 0);
            check("rst_da_valid", o_w_da_valid, 0);
            check("rst_ta_valid", o_w_ta_valid, 0);
            check("rst_sa_valid", o_w_sa_valid, 0);
            check("rst_done", o_refill_done, 0);
            m_busy = 0; m_req = 0; m_upd = 0; m_beats = 0; m_vic = 0;
            m_set = '0; m_tag = '0; m_nsa = '0;
        end else begin
            ph_req  = m_busy && m_req;
            ph_fill = m_busy && !m_req && m_beats < 4;
            ph_upd  = m_busy && m_beats == 4 && !m_upd;
            ph_done = m_busy && m_upd;
            e_mr = !m_busy && !i_halt;
            e_da = ph_fill && !i_halt && i_mem_rsp_valid;
            e_wr = ph_upd && !i_halt;
            e_dn = ph_done && !i_halt;

            check("miss_state", o_miss_state, m_busy);
            check("miss_ready", o_miss_ready, e_mr);
            check("req_valid", o_mem_req_valid, ph_req);
            if (ph_req) check("req_addr", o_mem_req_addr, {m_tag, m_set});
            check("rsp_ready", o_mem_rsp_ready, ph_fill && !i_halt);
            check("da_valid", o_w_da_valid, e_da);
            if (e_da) begin
                check("da_set", o_w_da_set_addr, m_set);
                check("da_way", o_w_da_way, m_vic);
                check("da_word", o_w_da_word, m_beats);
                check("da_data", o_w_da_data, i_mem_rsp_data);
            end
            check("ta_valid", o_w_ta_valid, e_wr);
            check("sa_valid", o_w_sa_valid, e_wr);
            if (e_wr) begin
                check("ta_set", o_w_ta_set_addr, m_set);
                check("ta_data", o_w_ta_data, {4{m_tag}});
                check("ta_mask", o_w_ta_mask, 4'b0001 << m_vic);
                check("sa_set", o_w_sa_set_addr, m_set);
                check("sa_data", o_w_sa_data, m_nsa);
                check("sa_mask", o_w_sa_mask, 4'b1111);
            end
            check("done", o_refill_done, e_dn);
            if (e_dn) check("done_way", o_refill_way, m_vic);

            if (o_miss_ready && i_miss_valid) st_miss_cyc = cyc;
            if (o_mem_req_valid) st_req_cycles++;
            if (o_mem_req_valid && i_mem_req_ready) st_req_addr = o_mem_req_addr;
            if (o_w_da_valid) begin
                if (st_da == 0) st_da_first = o_w_da_data;
                st_da_last = o_w_da_data;
                st_da++;
                st_words = {st_words[5:0], o_w_da_word};
                if (o_w_da_word == 2'd3) st_beat3_cyc = cyc;
            end
            if (o_w_ta_valid) begin
                st_ta++; st_ta_cyc = cyc;
                st_ta_data = o_w_ta_data; st_ta_mask = o_w_ta_mask;
            end
            if (o_w_sa_valid) st_sa_data = o_w_sa_data;
            if (o_refill_done) begin
                st_done++; st_done_cyc = cyc; st_done_way = o_refill_way;
            end

            if (e_mr && i_miss_valid) begin
                m_busy = 1; m_req = 1; m_upd = 0; m_beats = 0;
                m_set = i_miss_set_addr; m_tag = i_miss_tag;
                nru_model(i_miss_sa_data, m_vic, m_nsa);
            end else if (ph_req && i_mem_req_ready) m_req = 0;
            else if (e_da) m_beats++;
            else if (e_wr) m_upd = 1;
            else if (e_dn) m_busy = 0;
        end
    end

    // Stimulus knobs
    int p_req, p_rsp, p_halt, req_hold, rsp_gap, halt_after_beat, halt_len, reset_after_beat;
    bit directed_data;
    int beats_seen, halt_cnt, req_wait, gap_cnt;
    bit drv_miss_hs, drv_done, drv_rst_done;

    // One cycle: observe handshakes mid-cycle, then drive the next cycle's inputs just after the edge.
    task automatic tick();
        bit rsp_hs;
        @(negedge clk);
        rsp_hs      = o_mem_rsp_ready && i_mem_rsp_valid;
        drv_miss_hs = o_miss_ready && i_miss_valid;
        drv_done    = o_refill_done;
        @(posedge clk);
        #1;
        if (!arst_n) begin
            arst_n = 1'b1;
            drv_rst_done = 1'b1;
        end
        if (drv_miss_hs) begin
            i_miss_valid = 1'b0;
            req_wait = req_hold;
        end
        if (rsp_hs) begin
            beats_seen++;
            gap_cnt = rsp_gap;
            if (beats_seen == halt_after_beat) halt_cnt = halt_len;
            if (beats_seen == reset_after_beat) arst_n = 1'b0;
        end
        if (halt_cnt > 0) begin
            i_halt = 1'b1; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b1;
            halt_cnt--;
        end else begin
            i_halt          = int'($urandom_range(99)) < p_halt;
            i_mem_req_ready = !i_halt && (int'($urandom_range(99)) < p_req);
            i_mem_rsp_valid = int'($urandom_range(99)) < p_rsp;
        end
        if (req_wait > 0) begin
            i_mem_req_ready = 1'b0;
            req_wait--;
        end
        if (gap_cnt > 0) begin
            i_mem_rsp_valid = 1'b0;
            gap_cnt--;
        end
        i_mem_rsp_data = directed_data ? 32'h11 * (beats_seen + 1) : $urandom();
    endtask

    task automatic refill(input logic [3:0] set, input logic [7:0] tag, input logic [7:0] sa);
        int n;
        bit fin;
        beats_seen = 0; halt_cnt = 0; gap_cnt = 0; req_wait = 0; drv_rst_done = 0;
        st_da = 0; st_ta = 0; st_done = 0; st_req_cycles = 0; st_words = '0;
        st_miss_cyc = 0; st_done_cyc = 0; st_beat3_cyc = 0; st_ta_cyc = 0;
        i_miss_set_addr = set; i_miss_tag = tag; i_miss_sa_data = sa; i_miss_valid = 1'b1;
        fin = 0; n = 0;
        while (!fin) begin
            tick();
            n++;
            if (drv_done || drv_rst_done) fin = 1;
            else if (n >= 400) begin
                n_tests++; n_fail++;
                $display("FAIL refill_timeout: no completion after %0d cycles, required <400", n);
                fin = 1;
            end
        end
        i_miss_valid = 1'b0;
    endtask

    task automatic set_directed();
        p_req = 100; p_rsp = 100; p_halt = 0; req_hold = 0; rsp_gap = 0;
        halt_after_beat = -1; halt_len = 0; reset_after_beat = -1; directed_data = 1;
    endtask

    initial begin
        #500000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        arst_n = 1'b0; i_halt = 0; i_miss_valid = 0; i_miss_set_addr = 0; i_miss_tag = 0;
        i_miss_sa_data = 0; i_mem_req_ready = 0; i_mem_rsp_valid = 0; i_mem_rsp_data = 0;
        set_directed();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_miss_ready", o_miss_ready, 1);
        check("reset_miss_state", o_miss_state, 0);
        check("reset_ta_valid", o_w_ta_valid, 0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        tick();

        // Zero-wait refill into an empty set
        refill(4'h5, 8'hA3, 8'h00);
        check("t1_req_addr", st_req_addr, 12'hA35);
        check("t1_da_count", st_da, 4);
        check("t1_da_first", st_da_first, 32'h11);
        check("t1_da_last", st_da_last, 32'h44);
        check("t1_words", st_words, 8'h1B);
        check("t1_ta_data", st_ta_data, 32'hA3A3A3A3);
        check("t1_ta_mask", st_ta_mask, 4'b0001);
        check("t1_sa_data", st_sa_data, 8'h03);
        check("t1_latency", st_done_cyc - st_miss_cyc, 7);
        check("t1_way", st_done_way, 0);

        // Way 1 is the only non-recent way; all-recent triggers the clear
        refill(4'h3, 8'h5C, 8'hFB);
        check("t2_sa_data", st_sa_data, 8'hAE);
        check("t2_ta_mask", st_ta_mask, 4'b0010);
        check("t2_way", st_done_way, 1);

        // Slow request acceptance and gapped beats
        req_hold = 3; rsp_gap = 2;
        refill(4'hC, 8'h7E, 8'h02);
        check("t3_req_cycles", st_req_cycles, 4);
        check("t3_req_addr", st_req_addr, 12'h7EC);
        check("t3_da_count", st_da, 4);
        check("t3_words", st_words, 8'h1B);
        check("t3_update_gap", st_ta_cyc - st_beat3_cyc, 1);
        check("t3_ta_count", st_ta, 1);
        set_directed();

        // Halt for two cycles after the first beat with response data waiting
        halt_after_beat = 1; halt_len = 2;
        refill(4'h9, 8'h10, 8'h0F);
        check("t4a_da_count", st_da, 4);
        check("t4a_latency", st_done_cyc - st_miss_cyc, 9);
        // Halt covering the update cycle
        halt_after_beat = 4; halt_len = 2;
        refill(4'h1, 8'h22, 8'h55);
        check("t4b_update_gap", st_ta_cyc - st_beat3_cyc, 3);
        check("t4b_latency", st_done_cyc - st_miss_cyc, 9);
        check("t4b_ta_count", st_ta, 1);
        set_directed();

        // Reset after the second beat abandons the refill
        reset_after_beat = 2;
        refill(4'hE, 8'hB7, 8'h3C);
        check("t5_da_count", st_da, 2);
        check("t5_ta_count", st_ta, 0);
        check("t5_done_count", st_done, 0);
        @(negedge clk);
        check("t5_miss_ready", o_miss_ready, 1);
        check("t5_miss_state", o_miss_state, 0);
        @(posedge clk);
        #1;
        reset_after_beat = -1;
        refill(4'hE, 8'hB7, 8'h3C);
        check("t5_retry_done", st_done, 1);
        check("t5_retry_ta_mask", st_ta_mask, 4'b0001);

        // Randomised refills with back-pressure, halts and occasional resets
        for (int i = 0; i < 40; i++) begin
            p_req = $urandom_range(30, 100);
            p_rsp = $urandom_range(30, 100);
            p_halt = $urandom_range(0, 25);
            directed_data = 0;
            reset_after_beat = ($urandom_range(7) == 0) ? int'($urandom_range(1, 3)) : -1;
            refill(4'($urandom()), 8'($urandom()), 8'($urandom()));
            if (!drv_rst_done) begin
                check("rnd_da_count", st_da, 4);
                check("rnd_ta_count", st_ta, 1);
                check("rnd_done_count", st_done, 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
